// File: rtl/backward_update.sv
// backward_update: SGD backprop and weight-update engine for the 2-4-1 XOR net.
// Optional err_out port (last output error) is enabled by BACKWARD_ERR_OUT_EN.

module Floating_Point_Adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [31:0]       w_x, w_s;
  logic [7:0]        w_d;
  logic [26:0]       w_mx, w_my, w_ms, w_n;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic              w_up;
  logic [24:0]       w_r;
  logic signed [9:0] w_e;

  // align, add or subtract, normalise, round to nearest even; denormals flush
  always_comb begin
    if (i_b[30:0] > i_a[30:0]) begin
      w_x = i_b;
      w_s = i_a;
    end else begin
      w_x = i_a;
      w_s = i_b;
    end
    w_d  = w_x[30:23] - w_s[30:23];
    w_mx = {1'b1, w_x[22:0], 3'b000};
    w_my = (w_s[30:23] == 8'd0) ? 27'd0 : {1'b1, w_s[22:0], 3'b000};
    if (w_d > 8'd26)
      w_ms = {26'd0, |w_my};
    else
      w_ms = (w_my >> w_d)
           | {26'd0, |(w_my & ~({27{1'b1}} << w_d))};
    if (w_x[31] ^ w_s[31])
      w_sum = {1'b0, w_mx} - {1'b0, w_ms};
    else
      w_sum = {1'b0, w_mx} + {1'b0, w_ms};
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (w_sum[i]) w_lz = 5'(26 - i);
    w_e = $signed({2'b00, w_x[30:23]});
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'sd1;
    end else begin
      w_n = w_sum[26:0] << w_lz;
      w_e = w_e - $signed({5'd0, w_lz});
    end
    w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_r  = {1'b0, w_n[26:3]} + {24'd0, w_up};
    if (w_r[24]) w_e = w_e + 10'sd1;
    o_y = {w_x[31], w_e[7:0], w_r[24] ? w_r[23:1] : w_r[22:0]};
    if (w_x[30:23] == 8'd0)
      o_y = {w_x[31] & w_s[31], 31'd0};
    else if (w_sum == 28'd0)
      o_y = 32'd0;
    else if (w_e <= 10'sd0)
      o_y = {w_x[31], 31'd0};
    else if (w_e >= 10'sd255)
      o_y = {w_x[31], 8'hFF, 23'd0};
  end
endmodule

module Floating_Point_Multiplier (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [47:0]       w_p;
  logic [23:0]       w_m;
  logic              w_g, w_st, w_sg;
  logic [24:0]       w_r;
  logic signed [9:0] w_e;

  // 24x24 mantissa product, normalise, round to nearest even; denormals flush
  always_comb begin
    w_sg = i_a[31] ^ i_b[31];
    w_p  = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    w_e  = $signed({2'b00, i_a[30:23]})
         + $signed({2'b00, i_b[30:23]}) - 10'sd127;
    if (w_p[47]) begin
      w_m  = w_p[47:24];
      w_g  = w_p[23];
      w_st = |w_p[22:0];
      w_e  = w_e + 10'sd1;
    end else begin
      w_m  = w_p[46:23];
      w_g  = w_p[22];
      w_st = |w_p[21:0];
    end
    w_r = {1'b0, w_m} + {24'd0, w_g & (w_st | w_m[0])};
    if (w_r[24]) w_e = w_e + 10'sd1;
    o_y = {w_sg, w_e[7:0], w_r[24] ? w_r[23:1] : w_r[22:0]};
    if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0 || w_e <= 10'sd0)
      o_y = {w_sg, 31'd0};
    else if (w_e >= 10'sd255)
      o_y = {w_sg, 8'hFF, 23'd0};
  end
endmodule

module backward_update #(
  parameter logic [31:0] LR = 32'h3F000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         p_1,
  input  logic         p_2,
  input  logic         target,
  input  logic [127:0] h_in,
  input  logic [31:0]  y_in,
  input  logic [4:0]   rd_addr,
  output logic [31:0]  rd_data,
`ifdef BACKWARD_ERR_OUT_EN
  output logic [31:0]  err_out,
`endif
  output logic         busy,
  output logic         done
);
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] RST_VAL [17] = '{
    32'h3EF59C31, 32'hBE99EA21, 32'hBEF36E31, 32'h3FD109A5,
    32'hBDA6BBDB, 32'h3EE29AAC, 32'h3F30EE75, 32'h3FB25038,
    32'hBF1CF6D7, 32'h3D839D9E, 32'hBEC2C24C, 32'h3ECCB2DD,
    32'h3EEFD87D, 32'h3F6A6BC9, 32'h3F5A0A9B, 32'h3ED3C287,
    32'h3EA361BB};

  typedef enum logic [2:0] {
    S_IDLE, S_OUT_D, S_HID_D, S_UPD_O, S_UPD_H
  } state_t;

  state_t       r_st;
  logic [3:0]   r_sub;
  logic [1:0]   r_j;
  logic         r_x0, r_x1, r_tg;
  logic [127:0] r_h;
  logic [31:0]  r_y, r_e, r_om, r_m, r_d, r_g, r_t1, r_t2;
  logic [31:0]  r_gh [4];
  logic [31:0]  r_prm [17];
  logic [31:0]  w_aa, w_ab, w_ma, w_mb, w_add, w_mul, w_hj, w_ho;
  logic [4:0]   w_widx;
  logic [1:0]   w_k;

  function automatic logic [31:0] neg(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

  Floating_Point_Adder u_add (.i_a(w_aa), .i_b(w_ab), .o_y(w_add));
  Floating_Point_Multiplier u_mul (.i_a(w_ma), .i_b(w_mb), .o_y(w_mul));

  assign rd_data = (rd_addr <= 5'd16) ? r_prm[rd_addr] : 32'd0;

  // route the current micro-op's operands to the shared adder and multiplier
  always_comb begin
    w_k    = (r_st == S_UPD_O) ? r_sub[2:1] : r_j;
    w_hj   = r_h[32*w_k +: 32];
    w_ho   = r_prm[{3'b010, w_k}];
    case (r_sub[1:0])
      2'd0:    w_widx = {3'b011, r_j};
      2'd1:    w_widx = {3'b000, r_j};
      default: w_widx = {3'b001, r_j};
    endcase
    w_aa = ONE;
    w_ab = 32'd0;
    w_ma = 32'd0;
    w_mb = 32'd0;
    unique case (r_st)
      S_OUT_D:
        case (r_sub)
          4'd0: begin w_aa = r_y; w_ab = neg(r_tg ? ONE : 32'd0); end
          4'd1: w_ab = neg(r_y);
          4'd2: begin w_ma = r_y; w_mb = r_om; end
          4'd3: begin w_ma = r_e; w_mb = r_m; end
          default: begin w_ma = LR; w_mb = r_d; end
        endcase
      S_HID_D:
        case (r_sub)
          4'd0: w_ab = neg(w_hj);
          4'd1: begin w_ma = w_hj; w_mb = r_t1; end
          4'd2: begin w_ma = r_d; w_mb = w_ho; end
          4'd3: begin w_ma = r_t1; w_mb = r_t2; end
          default: begin w_ma = LR; w_mb = r_t1; end
        endcase
      S_UPD_O:
        if (r_sub == 4'd8) begin
          w_aa = r_prm[16];
          w_ab = neg(r_g);
        end else if (!r_sub[0]) begin
          w_ma = r_g;
          w_mb = w_hj;
        end else begin
          w_aa = w_ho;
          w_ab = neg(r_t1);
        end
      S_UPD_H: begin
        w_aa = r_prm[w_widx];
        w_ab = neg(r_gh[r_j]);
      end
      default: ;
    endcase
  end

  // sequencer: one micro-op per cycle, results committed on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_sub <= '0;
      r_j   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      r_x0  <= 1'b0;
      r_x1  <= 1'b0;
      r_tg  <= 1'b0;
      r_h   <= '0;
      r_y   <= '0;
      r_e   <= '0;
      r_om  <= '0;
      r_m   <= '0;
      r_d   <= '0;
      r_g   <= '0;
      r_t1  <= '0;
      r_t2  <= '0;
      for (int k = 0; k < 4; k++) r_gh[k] <= '0;
      for (int k = 0; k < 17; k++) r_prm[k] <= RST_VAL[k];
`ifdef BACKWARD_ERR_OUT_EN
      err_out <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (r_st)
        S_IDLE:
          if (start) begin
            r_x0  <= p_1;
            r_x1  <= p_2;
            r_tg  <= target;
            r_h   <= h_in;
            r_y   <= y_in;
            busy  <= 1'b1;
            r_sub <= '0;
            r_j   <= '0;
            r_st  <= S_OUT_D;
          end
        S_OUT_D: begin
          case (r_sub)
            4'd0:    r_e  <= w_add;
            4'd1:    r_om <= w_add;
            4'd2:    r_m  <= w_mul;
            4'd3:    r_d  <= w_mul;
            default: r_g  <= w_mul;
          endcase
          if (r_sub == 4'd4) begin
            r_sub <= '0;
            r_st  <= S_HID_D;
`ifdef BACKWARD_ERR_OUT_EN
            err_out <= r_e;
`endif
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        S_HID_D: begin
          case (r_sub)
            4'd0:    r_t1 <= w_add;
            4'd1:    r_t1 <= w_mul;
            4'd2:    r_t2 <= w_mul;
            4'd3:    r_t1 <= w_mul;
            default: r_gh[r_j] <= w_mul;
          endcase
          if (r_sub == 4'd4) begin
            r_sub <= '0;
            r_j   <= r_j + 2'd1;
            if (r_j == 2'd3) r_st <= S_UPD_O;
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        S_UPD_O: begin
          if (r_sub == 4'd8) begin
            r_prm[16] <= w_add;
            r_sub     <= '0;
            r_st      <= S_UPD_H;
          end else begin
            if (!r_sub[0]) r_t1 <= w_mul;
            else r_prm[{3'b010, r_sub[2:1]}] <= w_add;
            r_sub <= r_sub + 4'd1;
          end
        end
        S_UPD_H: begin
          if (r_sub == 4'd0 || (r_sub == 4'd1 && r_x0) ||
              (r_sub == 4'd2 && r_x1))
            r_prm[w_widx] <= w_add;
          if (r_sub == 4'd2) begin
            r_sub <= '0;
            r_j   <= r_j + 2'd1;
            if (r_j == 2'd3) begin
              r_st <= S_IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            r_sub <= r_sub + 4'd1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_backward_update.sv
// tb_backward_update: directed vector table for backward_update plus
// hand-written protocol and reset-during-update sequences.

module tb_backward_update;
  logic         clk = 1'b0;
  logic         rst, start, p_1, p_2, target;
  logic [127:0] h_in;
  logic [31:0]  y_in;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         busy, done;
`ifdef BACKWARD_ERR_OUT_EN
  logic [31:0]  err_out;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic             p1, p2, tg;
    logic [127:0]     h;
    logic [31:0]      y;
    logic [31:0]      ee;
    logic [16:0][31:0] ep;
  } vec_t;

  vec_t vt [4];

  logic [31:0] RV [17] = '{
    32'h3EF59C31, 32'hBE99EA21, 32'hBEF36E31, 32'h3FD109A5,
    32'hBDA6BBDB, 32'h3EE29AAC, 32'h3F30EE75, 32'h3FB25038,
    32'hBF1CF6D7, 32'h3D839D9E, 32'hBEC2C24C, 32'h3ECCB2DD,
    32'h3EEFD87D, 32'h3F6A6BC9, 32'h3F5A0A9B, 32'h3ED3C287,
    32'h3EA361BB};

  always #5 clk = ~clk;

  backward_update dut (
    .clk(clk), .rst(rst), .start(start),
    .p_1(p_1), .p_2(p_2), .target(target),
    .h_in(h_in), .y_in(y_in),
    .rd_addr(rd_addr), .rd_data(rd_data),
`ifdef BACKWARD_ERR_OUT_EN
    .err_out(err_out),
`endif
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] req);
    rd_addr = 5'(a);
    #1;
    chk($sformatf("%s[%0d]", nm, a), rd_data, req);
  endtask

  task automatic apply_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic set_in(input vec_t v);
    p_1    = v.p1;
    p_2    = v.p2;
    target = v.tg;
    h_in   = v.h;
    y_in   = v.y;
  endtask

  task automatic run_upd(input string nm);
    int n;
    n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'd46);
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    tick();
    chk({nm, " done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, nd;
    rst = 1'b1; start = 1'b0; p_1 = 1'b0; p_2 = 1'b0; target = 1'b0;
    h_in = '0; y_in = '0; rd_addr = '0;

    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 17; i++) vt[k].ep[i] = RV[i];
    // zero gradient: y equals target
    vt[0].p1 = 1; vt[0].p2 = 1; vt[0].tg = 1;
    vt[0].h  = {32'h3F19999A, 32'h3F400000, 32'h3E800000, 32'h3F000000};
    vt[0].y  = 32'h3F800000; vt[0].ee = 32'h00000000;
    // h = 0: only the output bias moves, by g = 0.0625
    vt[1].p1 = 1; vt[1].p2 = 1; vt[1].tg = 0;
    vt[1].h  = '0; vt[1].y = 32'h3F000000; vt[1].ee = 32'h3F000000;
    vt[1].ep[16] = 32'h3E8361BB;
    // inputs 00: input weights gated off
    vt[2].p1 = 0; vt[2].p2 = 0; vt[2].tg = 1;
    vt[2].h  = {4{32'h3F000000}}; vt[2].y = 32'h3F000000;
    vt[2].ee = 32'hBF000000;
    vt[2].ep[8]  = 32'hBF14F6D7; vt[2].ep[9]  = 32'h3DC39D9E;
    vt[2].ep[10] = 32'hBEB2C24C; vt[2].ep[11] = 32'h3EDCB2DD;
    vt[2].ep[12] = 32'h3EEAF0C6; vt[2].ep[13] = 32'h3F6AAD98;
    vt[2].ep[14] = 32'h3F588516; vt[2].ep[15] = 32'h3ED6F552;
    vt[2].ep[16] = 32'h3EC361BB;
    // inputs 10: only w_ih[0][*] follows the hidden gradients
    vt[3] = vt[2];
    vt[3].p1 = 1;
    vt[3].ep[0] = 32'h3EF0B47A; vt[3].ep[1] = 32'hBE996683;
    vt[3].ep[2] = 32'hBEF6793A; vt[3].ep[3] = 32'h3FD1D658;

    #2;
    rd_chk("rst_rd", 0, 32'h3EF59C31);
    rd_chk("rst_rd", 8, 32'hBF1CF6D7);
    rd_chk("rst_rd", 16, 32'h3EA361BB);
    rd_chk("rst_rd", 20, 32'h00000000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) begin
      apply_rst();
      set_in(vt[k]);
      run_upd($sformatf("vec%0d", k));
      for (int i = 0; i < 17; i++)
        rd_chk($sformatf("vec%0d prm", k), i, vt[k].ep[i]);
`ifdef BACKWARD_ERR_OUT_EN
      chk($sformatf("vec%0d err_out", k), err_out, vt[k].ee);
`endif
    end

    // start held high: one update per acceptance, restart right after done
    apply_rst();
    set_in(vt[0]);
    start = 1'b1;
    tick();
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("held busy_cycles", 32'(n), 32'd46);
    chk("held done", {31'd0, done}, 32'd1);
    tick();
    chk("held restart_busy", {31'd0, busy}, 32'd1);
    chk("held restart_done", {31'd0, done}, 32'd0);
    // a start pulse mid-update is ignored
    n = 0;
    while (busy && n < 100) begin
      start = (n == 10);
      n++;
      tick();
    end
    start = 1'b0;
    chk("pulse busy_cycles", 32'(n), 32'd46);
    chk("pulse done", {31'd0, done}, 32'd1);
    tick();
    chk("pulse idle_after", {31'd0, busy}, 32'd0);
    rd_chk("pulse prm", 16, 32'h3EA361BB);

    // reset during update discards partial work
    apply_rst();
    set_in(vt[2]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("midrst busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 17; i++) rd_chk("midrst prm", i, RV[i]);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (60) begin
      tick();
      if (done || busy) nd++;
    end
    chk("midrst no_done", 32'(nd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
